// File: rtl/simple_isa_pkg.sv
// rtl/simple_isa_pkg.sv - shared types and constants for the simple ISA datapath
package simple_isa_pkg;

  localparam int DATA_W   = 8;
  // Stage ids are sized for the largest supported requester count (8).
  localparam int MAX_ID_W = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } stage_t;

endpackage

// File: rtl/simple_alu_sched_rr_arbiter.sv
// rtl/simple_alu_sched_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic          found;
  int            idx;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
    if (advance && found) begin
      rr_ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/simple_alu_sched.sv
// rtl/simple_alu_sched.sv - shares one registered add/sub ALU among NUM_REQ requesters
module simple_alu_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = simple_isa_pkg::DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      alu_add0_sub1,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_o,
  output logic [15:0]               ops_done
);

  import simple_isa_pkg::*;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               granted;

  alu_op_e            alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  stage_t             s1_q, s1_d;
  stage_t             s2_q, s2_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [15:0]        ops_done_q, ops_done_d;

  // Ready is masked during reset so nothing appears accepted while flops are cleared.
  assign granted   = resetn & (|req_valid);
  assign req_ready = resetn ? gnt : '0;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_arbiter (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req_valid),
    .advance (granted),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    s1_d        = '0;
    s2_d        = s1_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    ops_done_d  = ops_done_q;
    if (granted) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          alu_op_d = alu_op_e'(req_op[i]);
          alu_a_d  = req_a[i*DATA_W +: DATA_W];
          alu_b_d  = req_b[i*DATA_W +: DATA_W];
        end
      end
      s1_d.vld = 1'b1;
      s1_d.id  = MAX_ID_W'(gnt_idx);
    end
    // alu_o is only trusted when a tracked op reaches stage 2; the ALU itself has no reset.
    if (s2_q.vld) begin
      rsp_valid_d = NUM_REQ'(1) << s2_q.id;
      rsp_data_d  = alu_o;
      ops_done_d  = ops_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_op_q    <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      ops_done_q  <= '0;
    end else begin
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign alu_add0_sub1 = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign ops_done      = ops_done_q;

endmodule
